// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared VGA timing constants, coordinate width and sync bundle type
package vga_timing_pkg;

  // Coordinate width shared with the overlay/frame drawing stages
  localparam int COORD_W   = 10;
  localparam int MAX_TOTAL = 1 << COORD_W;

  // 640x480@60 defaults with a 100 MHz system clock
  localparam int DEF_CLK_DIV   = 4;
  localparam int DEF_H_ACTIVE  = 640;
  localparam int DEF_H_FP      = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BP      = 48;
  localparam int DEF_V_ACTIVE  = 480;
  localparam int DEF_V_FP      = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BP      = 33;
  localparam int DEF_OUT_DELAY = 2;
  localparam logic DEF_SYNC_POL = 1'b0;

  // Sum of the four segments of a line or a frame
  function automatic int timing_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int H_TOTAL = timing_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int V_TOTAL = timing_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

  // Signals that travel through the output alignment delay together
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic video_on;
  } sync_bus_t;

endpackage

// File: rtl/sig_delay.sv
// rtl/sig_delay.sv - clk-rate shift register with synchronous flush; DEPTH=0 is a wire
module sig_delay #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign dout = din;
  end else begin : g_shift
    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    // Each stage takes the previous one; stage 0 takes the input
    always_comb begin
      stage_d[0] = din;
      for (int i = 1; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end

    // Advance every clk; reset flushes every stage to the idle value
    always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rst) stage_q[i] <= RST_VAL;
        else     stage_q[i] <= stage_d[i];
      end
    end

    assign dout = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - pixel tick divider, H/V counters and delayed sync/video decode
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int   CLK_DIV   = DEF_CLK_DIV,
  parameter int   H_ACTIVE  = DEF_H_ACTIVE,
  parameter int   H_FP      = DEF_H_FP,
  parameter int   H_SYNC    = DEF_H_SYNC,
  parameter int   H_BP      = DEF_H_BP,
  parameter int   V_ACTIVE  = DEF_V_ACTIVE,
  parameter int   V_FP      = DEF_V_FP,
  parameter int   V_SYNC    = DEF_V_SYNC,
  parameter int   V_BP      = DEF_V_BP,
  parameter logic SYNC_POL  = DEF_SYNC_POL,
  parameter int   OUT_DELAY = DEF_OUT_DELAY
) (
  input  logic               clk,
  input  logic               rst,
  output logic               pix_en,
  output logic [COORD_W-1:0] counter_x,
  output logic [COORD_W-1:0] counter_y,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic               line_start,
  output logic               frame_start
);

  localparam int HT    = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int VT    = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(HT - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(VT - 1);
  localparam logic [COORD_W-1:0] HS_FIRST = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_LAST  = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [COORD_W-1:0] VS_FIRST = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_LAST  = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_ACTIVE);

  localparam sync_bus_t SYNC_IDLE = '{hsync: ~SYNC_POL, vsync: ~SYNC_POL, video_on: 1'b0};

  if (HT > MAX_TOTAL || VT > MAX_TOTAL) begin : g_total_check
    $error("vga_sync_gen: line or frame total exceeds 1024");
  end
  if (CLK_DIV < 1) begin : g_div_check
    $error("vga_sync_gen: CLK_DIV must be at least 1");
  end

  logic [DIV_W-1:0]   div_q, div_d;
  logic               pix_en_q, pix_en_d;
  logic               run_q, run_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  sync_bus_t          raw;
  sync_bus_t          aligned;

  // Divider wraps at CLK_DIV-1; the tick is registered so it is low throughout reset
  always_comb begin
    div_d    = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    pix_en_d = (div_q == DIV_LAST);
    run_d    = run_q | pix_en_q;
  end

  // Column/line counters advance on the clk after a pixel tick and wrap at the totals
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (pix_en_q) begin
      if (x_q == H_LAST) begin
        x_d = '0;
        y_d = (y_q == V_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q    <= '0;
      pix_en_q <= 1'b0;
      run_q    <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
    end else begin
      div_q    <= div_d;
      pix_en_q <= pix_en_d;
      run_q    <= run_d;
      x_q      <= x_d;
      y_q      <= y_d;
    end
  end

  // Raw decode; video stays off until the first pixel tick so (0,0) in reset is not visible
  always_comb begin
    raw.hsync    = (x_q >= HS_FIRST && x_q <= HS_LAST) ? SYNC_POL : ~SYNC_POL;
    raw.vsync    = (y_q >= VS_FIRST && y_q <= VS_LAST) ? SYNC_POL : ~SYNC_POL;
    raw.video_on = (run_q | pix_en_q) && (x_q < H_VIS) && (y_q < V_VIS);
  end

  sig_delay #(
    .WIDTH   ($bits(sync_bus_t)),
    .DEPTH   (OUT_DELAY),
    .RST_VAL (SYNC_IDLE)
  ) u_align (
    .clk  (clk),
    .rst  (rst),
    .din  (raw),
    .dout (aligned)
  );

  assign pix_en      = pix_en_q;
  assign counter_x   = x_q;
  assign counter_y   = y_q;
  assign hsync       = aligned.hsync;
  assign vsync       = aligned.vsync;
  assign video_on    = aligned.video_on;
  assign line_start  = pix_en_q && (x_q == '0);
  assign frame_start = pix_en_q && (x_q == '0) && (y_q == '0);

endmodule
